icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, parametrised instruction cache between the fetch stage and a word-serial backing instruction memory. Hits return one 32-bit instruction word one cycle after acceptance. Misses refill a whole line over a valid/ready request port followed by LINE_WORDS data beats, then deliver the requested word. Supports a whole-cache flush (e.g. for FENCE.I) and optional hit/miss performance counters.

## Interface
- NUM_SETS, 64: number of lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  cache can accept a request this cycle.
- req_addr  in  ADDR_W  byte address of the instruction; bits [1:0] ignored.
- resp_valid  out  1  resp_data valid this cycle; single-cycle pulse, no back-pressure.
- resp_data  out  32  instruction word.
- flush  in  1  invalidate all lines (level-sampled, one cycle is enough).
- mem_req_valid  out  1  line-fill request to backing memory.
- mem_req_ready  in  1  backing memory accepts the request.
- mem_req_addr  out  ADDR_W  line-aligned byte address (low log2(LINE_WORDS)+2 bits zero).
- mem_rvalid  in  1  refill data beat present.
- mem_rdata  in  32  refill word; beats arrive in ascending word order, LINE_WORDS beats per request.
- hit_cnt, miss_cnt  out  32  performance counters; present only with ICACHE_PERF_CNT_EN.

## Operation
- Address split: word = addr[2 +: log2(LINE_WORDS)]; index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Per-line storage: valid bit (flops), tag, and LINE_WORDS data words.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
- IDLE: req_ready=1 unless flush is pending or asserted.
  - On an accepted request with valid && tag match (hit): resp_valid=1 next cycle with the stored word. The FSM stays in IDLE.
  - On a miss: capture addr and go to MISS_REQ.
- MISS_REQ: mem_req_valid=1 with a stable mem_req_addr until mem_req_ready. On the handshake, go to REFILL with beat counter = 0.
- REFILL:
  - Each mem_rvalid writes mem_rdata to word[beat] of the indexed line and increments beat.
  - When beat LINE_WORDS-1 is written, write the tag and set valid.
  - The beat matching the captured word offset is latched as the response.
  - Then go to RESP.
- RESP: resp_valid=1 for one cycle with the latched word; go to IDLE.
- mem_rvalid outside REFILL is ignored.
- Flush:
  - In IDLE: clears all valid bits at that edge. Flush wins over a simultaneous req_valid (req_ready=0 that cycle).
  - During MISS_REQ/REFILL/RESP: latched as pending. The refill completes and its response is delivered. All valids, including the new line, are cleared on the first IDLE cycle, with req_ready=0 in that cycle.
- Reset:
  - State = IDLE; all valid bits = 0; pending flush = 0; beat = 0.
  - Outputs: resp_valid = 0, resp_data = 32'h0000_0013 (NOP), mem_req_valid = 0, mem_req_addr = 0, counters = 0.
  - Reset mid-refill abandons the fill; the partially written line stays invalid.

## Timing
- Hit latency: request accepted at edge N, resp_valid high in cycle N+1. Back-to-back hits sustain 1 per cycle.
- Miss: mem_req_valid rises in cycle N+1. After the handshake, LINE_WORDS beats arrive (gaps allowed). resp_valid is asserted in the cycle after the last beat edge. req_ready returns high the cycle after RESP.
- resp_data holds its last value when resp_valid=0.
- A miss to the same index as a just-completed refill behaves as a normal miss; there are no outstanding-miss merges.

## Configuration
- ICACHE_PERF_CNT_EN defined:
  - hit_cnt increments on each accepted hit; miss_cnt increments on each accepted miss.
  - Both counters are 32-bit, wrap at 2^32, and are cleared only by rst.
- Undefined: hit_cnt/miss_cnt ports and logic are absent.

## Structure
- icache_pkg: state enum, NOP constant 32'h0000_0013, and helper functions computing index/offset/tag widths from the parameters.
- Sub-module icache_line_ram: synchronous-read, single-write-port data array (NUM_SETS*LINE_WORDS words) with BRAM-inferable coding. Tags and valids stay in the top.
- Elaboration check: fail if NUM_SETS or LINE_WORDS is not a power of two.

## Test plan
- Reset → resp_valid=0, mem_req_valid=0, resp_data=32'h00000013, req_ready=1 one cycle after rst falls.
- Cold miss at 0x40 (defaults): mem_req_addr=0x40. Return beats 0xA0,0xA1,0xA2,0xA3 → one resp_valid with 0xA0. A second request to 0x44 hits: resp 0xA1 one cycle after acceptance, no mem request.
- Miss at 0x4C with mem_req_ready held low 5 cycles and a 2-cycle gap between beats → mem_req_addr=0x40 stays stable; response = beat 3; exactly one resp_valid.
- Conflict: fill 0x40, then request 0x40+NUM_SETS*LINE_WORDS*4=0x440 → miss and refill. A following 0x40 misses again.
- Flush asserted during REFILL → the response is still delivered; req_ready=0 on the first IDLE cycle. The next request to the same address misses.
- With ICACHE_PERF_CNT_EN: 3 misses + 5 hits → hit_cnt=5, miss_cnt=3. rst clears both to 0.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared types, constants and width helpers for the direct-mapped
// instruction cache (icache_dm and icache_line_ram).
//   state_e         - cache controller FSM states
//   Nop             - reset value of the response word (addi x0, x0, 0)
//   off_w/idx_w/tag_w - address field widths derived from the cache geometry
//   is_pow2         - geometry legality check used at elaboration
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMissReq,
    StRefill,
    StResp
  } state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Two bits below the word offset select the byte inside a 32-bit word.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned num_sets,
                                        input int unsigned line_words);
    return addr_w - idx_w(num_sets) - off_w(line_words) - 2;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: single-write-port, synchronous-read data array for the cache
// lines, written so that it maps onto a block RAM.
//   clk_i   - clock
//   we_i    - write enable for wdata_i at waddr_i
//   waddr_i - write word address {index, word}
//   wdata_i - write data
//   raddr_i - read word address {index, word}
//   rdata_o - read data, valid the cycle after raddr_i is presented
module icache_line_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache between fetch and a word-serial
// backing memory. Hits respond one cycle after acceptance; misses fetch a whole
// line (one request, LINE_WORDS beats) and then respond with the requested word.
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit_cnt/miss_cnt counters.
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready/req_addr - fetch request
//   resp_valid/resp_data        - one-cycle response pulse and instruction word
//   flush                       - invalidate all lines
//   mem_req_valid/ready/addr    - line-fill request to backing memory
//   mem_rvalid/mem_rdata        - refill beats, ascending word order
//   hit_cnt/miss_cnt            - performance counters (ICACHE_PERF_CNT_EN only)
module icache_dm
  import icache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned OffW = off_w(LINE_WORDS);
  localparam int unsigned IdxW = idx_w(NUM_SETS);
  localparam int unsigned TagW = tag_w(ADDR_W, NUM_SETS, LINE_WORDS);
  localparam logic [OffW-1:0] LastBeat = OffW'(LINE_WORDS - 1);

  if (!is_pow2(NUM_SETS) || !is_pow2(LINE_WORDS)) begin : g_param_check
    $error("icache_dm: NUM_SETS and LINE_WORDS must be powers of two >= 2");
  end

  logic [OffW-1:0] req_off;
  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;
  logic            unused_addr;

  assign req_off     = req_addr[2 +: OffW];
  assign req_idx     = req_addr[2 + OffW +: IdxW];
  assign req_tag     = req_addr[ADDR_W-1 -: TagW];
  assign unused_addr = ^req_addr[1:0];

  state_e            state_q;
  logic [OffW-1:0]   beat_q, off_q;
  logic [IdxW-1:0]   idx_q;
  logic [TagW-1:0]   tag_cap_q;
  logic [NUM_SETS-1:0] valid_q;
  logic [TagW-1:0]   tag_q [NUM_SETS];
  logic              flush_pend_q;
  logic              resp_valid_q, hit_q;
  logic [31:0]       data_q, fill_q, ram_rdata;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;

  logic hit, accept, refill_we, last_beat, off_match;

  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign req_ready = (state_q == StIdle) && !flush && !flush_pend_q;
  assign accept    = req_valid && req_ready;
  assign refill_we = (state_q == StRefill) && mem_rvalid;
  assign last_beat = (beat_q == LastBeat);
  assign off_match = (beat_q == off_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      beat_q          <= '0;
      off_q           <= '0;
      idx_q           <= '0;
      tag_cap_q       <= '0;
      valid_q         <= '0;
      flush_pend_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      hit_q           <= 1'b0;
      data_q          <= Nop;
      fill_q          <= Nop;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      // Keep the last hit word visible after the RAM read port moves on.
      if (hit_q) begin
        data_q <= ram_rdata;
      end
      if (flush && (state_q != StIdle)) begin
        flush_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (flush || flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (req_valid) begin
            if (hit) begin
              resp_valid_q <= 1'b1;
              hit_q        <= 1'b1;
            end else begin
              tag_cap_q       <= req_tag;
              idx_q           <= req_idx;
              off_q           <= req_off;
              mem_req_addr_q  <= {req_tag, req_idx, {(OffW + 2){1'b0}}};
              mem_req_valid_q <= 1'b1;
              state_q         <= StMissReq;
            end
          end
        end
        StMissReq: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat_q          <= '0;
            state_q         <= StRefill;
          end
        end
        StRefill: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + OffW'(1);
            if (off_match) begin
              fill_q <= mem_rdata;
            end
            if (last_beat) begin
              valid_q[idx_q] <= 1'b1;
              // Response word moves to the output register only now, so
              // resp_data stays stable until the response cycle.
              data_q         <= off_match ? mem_rdata : fill_q;
              resp_valid_q   <= 1'b1;
              state_q        <= StResp;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Tags need no reset: the valid bits guard them.
  always_ff @(posedge clk) begin
    if (refill_we && last_beat) begin
      tag_q[idx_q] <= tag_cap_q;
    end
  end

  icache_line_ram #(
    .Depth(NUM_SETS * LINE_WORDS),
    .AddrW(IdxW + OffW)
  ) u_line_ram (
    .clk_i  (clk),
    .we_i   (refill_we),
    .waddr_i({idx_q, beat_q}),
    .wdata_i(mem_rdata),
    .raddr_i({req_idx, req_off}),
    .rdata_o(ram_rdata)
  );

  assign resp_valid    = resp_valid_q;
  assign resp_data     = hit_q ? ram_rdata : data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed, table-driven bench for icache_dm at default geometry
// (64 sets, 4 words per line, 32-bit addresses) with a scripted backing memory.
module tb_icache_dm;

  localparam int unsigned LineWords = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_dm #(
    .NUM_SETS  (64),
    .LINE_WORDS(LineWords),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .flush        (flush),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    logic [31:0] maddr;
    logic [31:0] base;
    int          dly;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (req_ready !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    chk1("req_ready_wait", req_ready, 1'b1);
  endtask

  // One fetch; on a miss plays the backing memory with the given request
  // delay, inter-beat gap, and optional flush on beat fl_beat.
  task automatic do_req(input logic [31:0] addr, input bit hit, input logic [31:0] maddr,
                        input logic [31:0] base, input int dly, input int gap,
                        input int fl_beat, input logic [31:0] exp);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    if (hit) begin
      exp_hits++;
      chk1("hit_valid", resp_valid, 1'b1);
      chk("hit_data", resp_data, exp);
      chk1("hit_no_mem", mem_req_valid, 1'b0);
    end else begin
      exp_miss++;
      chk1("miss_no_resp", resp_valid, 1'b0);
      chk1("mem_req_valid", mem_req_valid, 1'b1);
      chk("mem_req_addr", mem_req_addr, maddr);
      for (int c = 0; c < dly; c++) begin
        mem_rvalid = 1'b1;  // stray beat outside REFILL must be ignored
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        chk("mem_addr_stable", mem_req_addr, maddr);
        chk1("mem_valid_held", mem_req_valid, 1'b1);
      end
      mem_rvalid    = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk1("mem_req_drop", mem_req_valid, 1'b0);
      for (int w = 0; w < LineWords; w++) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk1("gap_no_resp", resp_valid, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = base + 32'(w);
        flush      = (w == fl_beat);
        tick();
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        if (w < LineWords - 1) chk1("early_resp", resp_valid, 1'b0);
      end
      chk1("miss_resp_valid", resp_valid, 1'b1);
      chk("miss_resp_data", resp_data, exp);
      tick();
      chk1("resp_single", resp_valid, 1'b0);
      chk("resp_hold", resp_data, exp);
      if (fl_beat >= 0) chk1("flush_idle_ready", req_ready, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h040, 1'b0, 32'h040, 32'hA0, 0, 0, 32'hA0};
    vecs[1] = '{32'h044, 1'b1, 32'h0,   32'h0,  0, 0, 32'hA1};
    vecs[2] = '{32'h440, 1'b0, 32'h440, 32'hB0, 1, 0, 32'hB0};
    vecs[3] = '{32'h44C, 1'b1, 32'h0,   32'h0,  0, 0, 32'hB3};
    vecs[4] = '{32'h04C, 1'b0, 32'h040, 32'hC0, 5, 2, 32'hC3};
    vecs[5] = '{32'h040, 1'b1, 32'h0,   32'h0,  0, 0, 32'hC0};
    vecs[6] = '{32'h108, 1'b0, 32'h100, 32'hD0, 0, 1, 32'hD2};
    vecs[7] = '{32'h104, 1'b1, 32'h0,   32'h0,  0, 0, 32'hD1};
    vecs[8] = '{32'h448, 1'b0, 32'h440, 32'hE0, 0, 0, 32'hE2};
    vecs[9] = '{32'h048, 1'b0, 32'h040, 32'hF0, 0, 0, 32'hF2};

    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    tick();
    tick();
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0000_0013);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    rst = 1'b0;
    tick();
    chk1("rst_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].addr, vecs[i].hit, vecs[i].maddr, vecs[i].base, vecs[i].dly,
             vecs[i].gap, -1, vecs[i].exp);
    end

    // Back-to-back hits on the 0x40 line (refilled with F0..F3).
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h40 + 32'(4 * i);
      tick();
      exp_hits++;
      chk1("b2b_valid", resp_valid, 1'b1);
      chk("b2b_data", resp_data, 32'hF0 + 32'(i));
    end
    req_valid = 1'b0;
    tick();
    chk1("b2b_end", resp_valid, 1'b0);
    chk("b2b_hold", resp_data, 32'hF3);

    // Flush in IDLE beats a simultaneous request and drops the line.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h44;
    #1;
    chk1("flush_blocks_ready", req_ready, 1'b0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk1("flush_no_resp", resp_valid, 1'b0);
    chk1("flush_no_mem", mem_req_valid, 1'b0);
    // Miss after flush, with another flush raised mid-refill.
    do_req(32'h44, 1'b0, 32'h40, 32'h10, 0, 0, 1, 32'h11);
    // The line filled under the pending flush must be gone.
    do_req(32'h44, 1'b0, 32'h40, 32'h20, 0, 0, -1, 32'h21);
    do_req(32'h48, 1'b1, 32'h0, 32'h0, 0, 0, -1, 32'h22);

`ifdef ICACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hit_cnt_rst", hit_cnt, 32'h0);
    chk("miss_cnt_rst", miss_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
